// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared state encoding and constants for the 9-bit count sequence checker.
package count_chk_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
   localparam logic [8:0] CNT_MAX = 9'h1FF;
   localparam int ERR_W_DEF = 8;
   localparam int SYNC_LEN_DEF = 2;
endpackage

// File: rtl/count_predict.sv
// count_predict: next expected counter value from the previous sample and the counter's controls.
module count_predict
   import count_chk_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] ref_i,
   input  logic             adv_i,
   input  logic             sclr_i,
   output logic [WIDTH-1:0] exp_o
);
   assign exp_o = sclr_i ? '0 : adv_i ? ((ref_i == CNT_MAX) ? '0 : ref_i + WIDTH'(1)) : ref_i;
endmodule

// File: rtl/count_seq_checker_9bit.sv
// count_seq_checker_9bit: locks onto a 9-bit up-counter sequence and flags deviations.
// Define PARITY_CHK_EN to also check the '280 parity outputs against each sample.
module count_seq_checker_9bit
   import count_chk_pkg::*;
#(
   parameter int WIDTH    = 9,
   parameter int ERR_W    = ERR_W_DEF,
   parameter int SYNC_LEN = SYNC_LEN_DEF
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sample_en,
   input  logic             adv,
   input  logic             sclr,
   input  logic [WIDTH-1:0] cin,
`ifdef PARITY_CHK_EN
   input  logic             par_even,
   input  logic             par_odd,
   output logic [ERR_W-1:0] par_err_count,
   output logic             par_err_pulse,
`endif
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] last_good
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d, last_good_q, last_good_d, exp_v;
   logic [3:0]       run_q, run_d, run_inc;
   logic             locked_q, locked_d, err_q, err_d, wrap_q, wrap_d, match;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   count_predict #(.WIDTH(WIDTH)) u_pred (.ref_i(ref_q), .adv_i(adv), .sclr_i(sclr), .exp_o(exp_v));

   assign match   = (cin == exp_v);
   assign run_inc = run_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      run_d       = run_q;
      locked_d    = locked_q;
      err_d       = 1'b0;
      wrap_d      = 1'b0;
      err_cnt_d   = err_cnt_q;
      last_good_d = last_good_q;
      if (sample_en) begin
         ref_d = cin;
         case (state_q)
            IDLE: begin
               run_d   = '0;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               run_d       = match ? run_inc : '0;
               last_good_d = match ? cin : last_good_q;
               if (match && run_inc == 4'(SYNC_LEN)) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end
            end
            LOCKED: begin
               if (match) begin
                  last_good_d = cin;
                  wrap_d      = (ref_q == CNT_MAX) && adv && !sclr;
               end else begin
                  err_d     = 1'b1;
                  err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
                  run_d     = '0;
                  state_d   = ACQUIRE;
                  locked_d  = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= IDLE;
         ref_q       <= '0;
         run_q       <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         err_cnt_q   <= '0;
         last_good_q <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         run_q       <= run_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         wrap_q      <= wrap_d;
         err_cnt_q   <= err_cnt_d;
         last_good_q <= last_good_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_q;
   assign wrap_pulse = wrap_q;
   assign err_count  = err_cnt_q;
   assign last_good  = last_good_q;

`ifdef PARITY_CHK_EN
   logic             par_bad, par_pulse_d, par_pulse_q;
   logic [ERR_W-1:0] par_cnt_d, par_cnt_q;

   assign par_bad     = (par_even != ~^cin) || (par_odd != ^cin);
   assign par_pulse_d = sample_en && (state_q != IDLE) && par_bad;
   assign par_cnt_d   = (par_pulse_d && par_cnt_q != '1) ? par_cnt_q + ERR_W'(1) : par_cnt_q;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         par_pulse_q <= 1'b0;
         par_cnt_q   <= '0;
      end else begin
         par_pulse_q <= par_pulse_d;
         par_cnt_q   <= par_cnt_d;
      end
   end

   assign par_err_pulse = par_pulse_q;
   assign par_err_count = par_cnt_q;
`endif
endmodule

// File: tb/tb_count_seq_checker_9bit.sv
// tb_count_seq_checker_9bit: directed vector table plus hand sequences for reset, saturation and parity.
module tb_count_seq_checker_9bit;
   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       sample_en = 1'b0, adv = 1'b0, sclr = 1'b0;
   logic [8:0] cin = '0;
   logic       locked, err_pulse, wrap_pulse;
   logic [7:0] err_count;
   logic [8:0] last_good;
   int         n_tests = 0, n_fail = 0;
`ifdef PARITY_CHK_EN
   logic       par_even = 1'b1, par_odd = 1'b0, par_err_pulse;
   logic [7:0] par_err_count;
`endif

   count_seq_checker_9bit dut (
      .clk(clk), .clear_n(clear_n), .sample_en(sample_en), .adv(adv), .sclr(sclr), .cin(cin),
`ifdef PARITY_CHK_EN
      .par_even(par_even), .par_odd(par_odd), .par_err_count(par_err_count), .par_err_pulse(par_err_pulse),
`endif
      .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count), .last_good(last_good)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       se, adv, sclr;
      logic [8:0] cin;
      logic       locked, err, wrap;
      logic [7:0] cnt;
      logic [8:0] lg;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t v(logic se, logic a, logic s, logic [8:0] c, logic l, logic e, logic w, logic [7:0] n, logic [8:0] g);
      vec_t r;
      r.se = se; r.adv = a; r.sclr = s; r.cin = c; r.locked = l; r.err = e; r.wrap = w; r.cnt = n; r.lg = g;
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic drive(input logic se, input logic a, input logic s, input logic [8:0] c, input logic bad_even);
      @(negedge clk);
      sample_en = se; adv = a; sclr = s; cin = c;
`ifdef PARITY_CHK_EN
      par_even = (~^c) ^ bad_even;
      par_odd  = ^c;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string n);
      chk({n, " locked"}, 32'(locked), 0);
      chk({n, " err_pulse"}, 32'(err_pulse), 0);
      chk({n, " wrap_pulse"}, 32'(wrap_pulse), 0);
      chk({n, " err_count"}, 32'(err_count), 0);
      chk({n, " last_good"}, 32'(last_good), 0);
`ifdef PARITY_CHK_EN
      chk({n, " par_err_pulse"}, 32'(par_err_pulse), 0);
      chk({n, " par_err_count"}, 32'(par_err_count), 0);
`endif
   endtask

   task automatic mid_reset(input string n);
      #2 clear_n = 1'b0;
      #1 chk_all_zero(n);
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   initial begin
      logic [8:0] val, w;
      int         exp_cnt;
      tbl[0]  = v(1,1,0,9'h000, 0,0,0,0,9'h000);
      tbl[1]  = v(1,1,0,9'h001, 0,0,0,0,9'h001);
      tbl[2]  = v(1,1,0,9'h002, 1,0,0,0,9'h002);
      tbl[3]  = v(0,1,0,9'h055, 1,0,0,0,9'h002);
      tbl[4]  = v(1,0,0,9'h002, 1,0,0,0,9'h002);
      tbl[5]  = v(1,1,0,9'h003, 1,0,0,0,9'h003);
      tbl[6]  = v(1,1,0,9'h004, 1,0,0,0,9'h004);
      tbl[7]  = v(1,1,0,9'h005, 1,0,0,0,9'h005);
      tbl[8]  = v(1,1,0,9'h007, 0,1,0,1,9'h005);
      tbl[9]  = v(1,1,0,9'h008, 0,0,0,1,9'h008);
      tbl[10] = v(1,1,0,9'h009, 1,0,0,1,9'h009);
      tbl[11] = v(1,1,1,9'h000, 1,0,0,1,9'h000);
      tbl[12] = v(1,1,0,9'h1FE, 0,1,0,2,9'h000);
      tbl[13] = v(1,0,0,9'h1FE, 0,0,0,2,9'h1FE);
      tbl[14] = v(1,0,0,9'h1FE, 1,0,0,2,9'h1FE);
      tbl[15] = v(1,1,0,9'h1FF, 1,0,0,2,9'h1FF);
      tbl[16] = v(1,1,0,9'h000, 1,0,1,2,9'h000);
      tbl[17] = v(1,1,0,9'h001, 1,0,0,2,9'h001);
      tbl[18] = v(1,1,0,9'h0A3, 0,1,0,3,9'h001);
      tbl[19] = v(1,0,0,9'h0A3, 0,0,0,3,9'h0A3);
      tbl[20] = v(1,0,0,9'h0A3, 1,0,0,3,9'h0A3);
      tbl[21] = v(1,0,1,9'h000, 1,0,0,3,9'h000);
      tbl[22] = v(1,0,0,9'h0A3, 0,1,0,4,9'h000);
      tbl[23] = v(1,0,0,9'h0A3, 0,0,0,4,9'h0A3);
      tbl[24] = v(1,0,0,9'h0A3, 1,0,0,4,9'h0A3);
      tbl[25] = v(1,0,1,9'h0A4, 0,1,0,5,9'h0A3);
      tbl[26] = v(0,0,0,9'h000, 0,0,0,5,9'h0A3);

      #3 chk_all_zero("reset");
      @(negedge clk);
      clear_n = 1'b1;
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].se, tbl[i].adv, tbl[i].sclr, tbl[i].cin, 1'b0);
         chk($sformatf("v%0d locked", i), 32'(locked), 32'(tbl[i].locked));
         chk($sformatf("v%0d err_pulse", i), 32'(err_pulse), 32'(tbl[i].err));
         chk($sformatf("v%0d wrap_pulse", i), 32'(wrap_pulse), 32'(tbl[i].wrap));
         chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d last_good", i), 32'(last_good), 32'(tbl[i].lg));
      end
      mid_reset("async reset");

      drive(1, 0, 0, 9'h000, 0);
      chk("reseed locked", 32'(locked), 0);
      drive(1, 0, 0, 9'h000, 0);
      drive(1, 0, 0, 9'h000, 0);
      chk("sat lock", 32'(locked), 1);
      val = 9'h000;
      exp_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         w = val ^ 9'h001;
         drive(1, 0, 0, w, 0);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         chk($sformatf("sat%0d err_pulse", i), 32'(err_pulse), 1);
         chk($sformatf("sat%0d err_count", i), 32'(err_count), 32'(exp_cnt));
         drive(1, 0, 0, w, 0);
         drive(1, 0, 0, w, 0);
         val = w;
      end
      chk("sat final count", 32'(err_count), 255);
      chk("sat final locked", 32'(locked), 1);

`ifdef PARITY_CHK_EN
      mid_reset("par pre-reset");
      drive(1, 0, 0, 9'h007, 1);
      chk("par idle pulse", 32'(par_err_pulse), 0);
      drive(1, 0, 0, 9'h007, 1);
      chk("par pulse", 32'(par_err_pulse), 1);
      chk("par count", 32'(par_err_count), 1);
      chk("par lock unaffected", 32'(err_count), 0);
      drive(1, 0, 0, 9'h007, 0);
      chk("par pulse drop", 32'(par_err_pulse), 0);
      chk("par locked", 32'(locked), 1);
      mid_reset("par reset");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/count_seq_checker_9bit.md
Name: count_seq_checker_9bit

Overview:
- Sink-side monitor for the 9-bit up-counter stimulus used in the parity-checker benches.
- Samples the counter's output bus and predicts the next value from the counter's own control inputs (enable, clear).
- Locks onto the sequence, then flags any deviation: missed step, double step, bad wrap, or failed clear.
- Sits beside the DUT in the testbench and reports error and wrap events to the bench.

Parameters:
- WIDTH, 9: width of the sampled count bus.
- ERR_W, 8: width of the saturating error counter.
- SYNC_LEN, 2: consecutive correct predictions needed to enter LOCKED; legal range 1..15.

Ports:
- clk, input, 1: system clock, rising-edge active.
- clear_n, input, 1: asynchronous active-low reset.
- sample_en, input, 1: cin is valid this cycle; one sample per counter step.
- adv, input, 1: counter enable was high for the step that produced this sample.
- sclr, input, 1: counter clear was asserted since the previous sample; the expected value is 0.
- cin, input, WIDTH: sampled counter output.
- locked, output, 1: checker is tracking the sequence.
- err_pulse, output, 1: one-cycle pulse on a mismatch while locked.
- wrap_pulse, output, 1: one-cycle pulse on a correct 511 -> 0 wrap while locked.
- err_count, output, ERR_W: saturating count of mismatches.
- last_good, output, WIDTH: most recent sample that matched the prediction.

Behaviour:
- Reset (clear_n low, asynchronous): state = IDLE, ref = 0, run = 0. All outputs are 0: locked, err_pulse, wrap_pulse, err_count, last_good.
- Prediction, evaluated only when sample_en = 1:
  - If sclr = 1, exp = 0; sclr has priority over adv.
  - Else if adv = 1, exp = 0 when ref = 9'h1FF, otherwise ref + 1 (modulo 2^WIDTH).
  - Else exp = ref (hold).
- State machine:
  - IDLE: on sample_en, ref <= cin, run <= 0, go to ACQUIRE. No check is made.
  - ACQUIRE, on sample_en with match: run++, ref <= cin, last_good <= cin. When run+1 = SYNC_LEN, go to LOCKED and set locked = 1.
  - ACQUIRE, on sample_en with mismatch: run <= 0, ref <= cin. No error is counted.
  - LOCKED, on sample_en with match: ref <= cin, last_good <= cin. Assert wrap_pulse if ref = 9'h1FF, adv = 1 and sclr = 0.
  - LOCKED, on sample_en with mismatch: err_pulse = 1 and err_count++. ref <= cin (resync), run <= 0, go to ACQUIRE, locked <= 0.
- Latency and pulses:
  - All outputs are registered; a response appears on the clock edge that consumes the sample.
  - Pulses last exactly one cycle.
- Idle cycles: sample_en = 0 leaves state and ref unchanged, and the pulses read 0.
- err_count saturates at 2^ERR_W - 1 and never wraps.
- sclr = 1 with cin = 0 while locked is a match: no error, no wrap_pulse.
- Reset asserted mid-run clears everything immediately, independent of clk. The first sample after release only re-seeds ref.

Optional Feature:
- Macro: PARITY_CHK_EN.
- Defined:
  - Adds input ports par_even (1) and par_odd (1), driven by the '280 outputs.
  - Adds output par_err_count (ERR_W, saturating, reset 0) and output par_err_pulse (1).
  - On every sample_en, in any state other than IDLE, the block checks par_even = ~^cin and par_odd = ^cin. Any inequality pulses par_err_pulse and increments par_err_count.
  - Parity errors do not affect the lock state.
- Not defined: those ports and logic are absent; the behaviour is otherwise identical.

Decomposition:
- Shared package count_chk_pkg holds:
  - the state encoding (IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2)
  - CNT_MAX = 9'h1FF
  - default ERR_W and SYNC_LEN
- One sub-module, count_predict, is natural: purely combinational, computing exp from ref, adv and sclr.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release, then samples 0, 1, 2 with adv = 1 -> locked rises on the edge consuming sample 2; err_count = 0.
- Locked at 9'h1FE, then samples 1FF and 000 with adv = 1 -> a single wrap_pulse on the 000 sample; no error.
- Locked at 5 with adv = 1, then sample 7 -> err_pulse for one cycle, err_count = 1, locked = 0. Then 8 and 9 -> relock; last_good = 9.
- Locked at 0x0A3 with sclr = 1, then sample 0 -> match, no pulse. Same case with sample 0x0A4 -> err_pulse.
- Force 300 consecutive mismatches with ERR_W = 8 -> err_count holds at 255.
- PARITY_CHK_EN defined: cin = 9'h007 with par_even = 1 -> par_err_pulse, par_err_count = 1. Then clear_n pulsed low mid-cycle -> all outputs are 0 before the next edge.
